// File: rtl/des_key_pkg.sv
// Shared tables, widths and helpers for the sequential DES/3DES key schedule.
// Bit numbering follows FIPS 46-3: table entries are 1-based, bit 1 is the MSB.
package des_key_pkg;

  localparam int RND_W  = 4;
  localparam int KIDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Parity bits (FIPS 8,16,..,64) never appear in PC1, so subkeys ignore them.
  function automatic logic [55:0] pc1_perm(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = key[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] v, input logic [1:0] amt,
                                        input logic left);
    logic [27:0] r;
    r = v;
    if (left) begin
      if (amt == 2'd1)      r = {v[26:0], v[27]};
      else if (amt == 2'd2) r = {v[25:0], v[27:26]};
    end else begin
      if (amt == 2'd1)      r = {v[0], v[27:1]};
      else if (amt == 2'd2) r = {v[1:0], v[27:2]};
    end
    return r;
  endfunction

  function automatic logic odd_parity_err(input logic [63:0] key);
    logic err;
    err = 1'b0;
    for (int b = 0; b < 8; b++) if (~^key[8*b +: 8]) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/des_key_sched_seq_permute_out.sv
// PC-2 compression: 56-bit C/D register image to a 48-bit DES round subkey.
module permute_out (
  input  logic [55:0] cd_i,
  output logic [47:0] subkey_o
);

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  always_comb begin
    subkey_o = '0;
    for (int i = 0; i < 48; i++) subkey_o[47-i] = cd_i[56-PC2[i]];
  end

endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES/3DES round-key generator: one 48-bit subkey per cycle per key,
// forward (encrypt) or reverse (decrypt) order, under valid/ready backpressure.
module des_key_sched_seq
  import des_key_pkg::*;
#(
  parameter int NUM_KEYS     = 1,
  parameter int PARITY_CHECK = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [64*NUM_KEYS-1:0] key_in,
  input  logic [NUM_KEYS-1:0]    decrypt,
  output logic                   busy,
  output logic                   sk_valid,
  input  logic                   sk_ready,
  output logic [47:0]            subkey,
  output logic [RND_W-1:0]       round_idx,
  output logic [KIDX_W-1:0]      key_idx,
  output logic                   last,
  output logic [NUM_KEYS-1:0]    parity_err
);

  state_t                  state_q;
  logic [64*NUM_KEYS-1:0]  keys_q;
  logic [NUM_KEYS-1:0]     dec_q;
  logic [NUM_KEYS-1:0]     perr_q, perr_d;
  logic [55:0]             cd_q, cd_d;
  logic [47:0]             subkey_q, sk_d;
  logic [RND_W-1:0]        round_q, rnd_d;
  logic [KIDX_W-1:0]       kidx_q;
  logic                    valid_q, busy_q, last_q, last_d;

  logic [63:0]             key_cur, key_nxt;
  logic                    dec_cur, final_of_key, last_key;
  logic [1:0]              sh_amt;
  logic                    sh_left;

  always_comb begin
    key_cur = '0;
    key_nxt = '0;
    dec_cur = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (kidx_q == KIDX_W'(k)) begin
        key_cur = keys_q[64*k +: 64];
        dec_cur = dec_q[k];
      end
      if (kidx_q + 2'd1 == KIDX_W'(k)) key_nxt = keys_q[64*k +: 64];
    end
  end

  always_comb begin
    perr_d = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      perr_d[k] = (PARITY_CHECK != 0) && odd_parity_err(key_in[64*k +: 64]);
  end

  // A decrypt key starts from C16/D16, which equals the raw PC-1 result.
  always_comb begin
    sh_amt  = 2'd0;
    sh_left = 1'b1;
    rnd_d   = round_q;
    if (!valid_q) begin
      sh_amt = dec_cur ? 2'd0 : 2'(SHIFT[0]);
      rnd_d  = dec_cur ? 4'd15 : 4'd0;
    end else if (dec_cur) begin
      sh_amt  = 2'(SHIFT[round_q]);
      sh_left = 1'b0;
      rnd_d   = round_q - 4'd1;
    end else begin
      sh_amt = 2'(SHIFT[round_q + 4'd1]);
      rnd_d  = round_q + 4'd1;
    end
    cd_d = {rot28(cd_q[55:28], sh_amt, sh_left), rot28(cd_q[27:0], sh_amt, sh_left)};
  end

  assign final_of_key = dec_cur ? (round_q == 4'd0) : (round_q == 4'd15);
  assign last_key     = (kidx_q == KIDX_W'(NUM_KEYS - 1));
  assign last_d       = last_key && (dec_cur ? (rnd_d == 4'd0) : (rnd_d == 4'd15));

  permute_out u_pc2 (
    .cd_i     (cd_d),
    .subkey_o (sk_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      keys_q   <= '0;
      dec_q    <= '0;
      perr_q   <= '0;
      cd_q     <= '0;
      subkey_q <= '0;
      round_q  <= '0;
      kidx_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            keys_q  <= key_in;
            dec_q   <= decrypt;
            perr_q  <= perr_d;
            kidx_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cd_q    <= pc1_perm(key_cur);
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!valid_q) begin
            cd_q     <= cd_d;
            subkey_q <= sk_d;
            round_q  <= rnd_d;
            last_q   <= last_d;
            valid_q  <= 1'b1;
          end else if (sk_ready) begin
            if (final_of_key) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (last_key) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                // Key rollover: the PC-1 load of the next key happens here,
                // so only a single empty cycle separates the two streams.
                kidx_q <= kidx_q + 2'd1;
                cd_q   <= pc1_perm(key_nxt);
              end
            end else begin
              cd_q     <= cd_d;
              subkey_q <= sk_d;
              round_q  <= rnd_d;
              last_q   <= last_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign sk_valid   = valid_q;
  assign subkey     = subkey_q;
  assign round_idx  = round_q;
  assign key_idx    = kidx_q;
  assign last       = last_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Scoreboard bench for des_key_sched_seq: a 1-key and a 3-key instance checked
// against a FIPS-table reference model using cumulative-shift index arithmetic.
module tb_des_key_sched_seq;

  localparam int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] KAT = 64'h133457799BBCDFF1;

  typedef struct {
    logic [47:0] sk;
    int          rnd;
    int          kidx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         st1, rdy1, busy1, v1, last1;
  logic [63:0]  key1;
  logic [0:0]   dec1, perr1;
  logic [47:0]  sk1;
  logic [3:0]   rnd1;
  logic [1:0]   kidx1;

  logic         st3, rdy3, busy3, v3, last3;
  logic [191:0] key3;
  logic [2:0]   dec3, perr3;
  logic [47:0]  sk3;
  logic [3:0]   rnd3;
  logic [1:0]   kidx3;

  des_key_sched_seq #(.NUM_KEYS(1), .PARITY_CHECK(1)) dut1 (
    .clk(clk), .reset(reset), .start(st1), .key_in(key1), .decrypt(dec1),
    .busy(busy1), .sk_valid(v1), .sk_ready(rdy1), .subkey(sk1),
    .round_idx(rnd1), .key_idx(kidx1), .last(last1), .parity_err(perr1));

  des_key_sched_seq #(.NUM_KEYS(3), .PARITY_CHECK(1)) dut3 (
    .clk(clk), .reset(reset), .start(st3), .key_in(key3), .decrypt(dec3),
    .busy(busy3), .sk_valid(v3), .sk_ready(rdy3), .subkey(sk3),
    .round_idx(rnd3), .key_idx(kidx3), .last(last3), .parity_err(perr3));

  int   errs = 0;
  int   chks = 0;
  exp_t q1[$];
  exp_t q3[$];
  int   hs1 = 0;
  logic [47:0] last_sk1;
  logic rr1 = 1'b0, rr3 = 1'b0;
  logic stall1 = 1'b0, stall3 = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Round r subkey: C_r/D_r are C0/D0 rotated left by the sum of SHIFT[0..r].
  function automatic logic [47:0] ref_sk(input logic [63:0] key, input int r);
    logic        cd0 [56];
    logic [47:0] sk;
    int          cum, p, src;
    for (int i = 0; i < 56; i++) cd0[i] = key[64-T_PC1[i]];
    cum = 0;
    for (int j = 0; j <= r; j++) cum += T_SH[j];
    for (int i = 0; i < 48; i++) begin
      p = T_PC2[i] - 1;
      src = (p < 28) ? (p + cum) % 28 : 28 + (p - 28 + cum) % 28;
      sk[47-i] = cd0[src];
    end
    return sk;
  endfunction

  function automatic logic perr_of(input logic [63:0] key);
    for (int b = 0; b < 8; b++) if ($countones(key[8*b +: 8]) % 2 == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input int which, input logic [191:0] keys, input logic [2:0] dec,
                      input int n);
    exp_t x;
    for (int k = 0; k < n; k++)
      for (int t = 0; t < 16; t++) begin
        x.rnd  = dec[k] ? 15 - t : t;
        x.sk   = ref_sk(keys[64*k +: 64], x.rnd);
        x.kidx = k;
        x.last = (k == n - 1) && (t == 15);
        if (which == 1) q1.push_back(x); else q3.push_back(x);
      end
  endtask

  always @(negedge clk) begin
    if (stall1) chk("hold_valid1", v1, 1'b1);
    if (!reset && v1 === 1'b1) begin
      if (q1.size() == 0) chk("unexpected1", sk1, 48'h0 - 1);
      else begin
        chk("subkey1", sk1, q1[0].sk);
        chk("round1", rnd1, q1[0].rnd);
        chk("keyidx1", kidx1, q1[0].kidx);
        chk("last1", last1, q1[0].last);
        if (rdy1) begin
          if (last1) last_sk1 = sk1;
          void'(q1.pop_front());
          hs1++;
        end
      end
    end
    stall1 = !reset && v1 === 1'b1 && !rdy1;
  end

  always @(negedge clk) begin
    if (stall3) chk("hold_valid3", v3, 1'b1);
    if (!reset && v3 === 1'b1) begin
      if (q3.size() == 0) chk("unexpected3", sk3, 48'h0 - 1);
      else begin
        chk("subkey3", sk3, q3[0].sk);
        chk("round3", rnd3, q3[0].rnd);
        chk("keyidx3", kidx3, q3[0].kidx);
        chk("last3", last3, q3[0].last);
        if (rdy3) void'(q3.pop_front());
      end
    end
    stall3 = !reset && v3 === 1'b1 && !rdy3;
  end

  initial begin
    rdy1 = 1'b1;
    rdy3 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy1 = rr1 ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy3 = rr3 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic run1(input logic [63:0] key, input logic dec, input logic rr,
                      input logic timing, output logic [47:0] fs);
    int cyc;
    rr1 = rr;
    fs  = '0;
    @(posedge clk); #1;
    key1 = key; dec1 = dec; st1 = 1'b1;
    push(1, {128'h0, key}, {2'b0, dec}, 1);
    @(posedge clk); #1;
    st1 = 1'b0;
    @(negedge clk);
    chk("busy_accept1", busy1, 1'b1);
    chk("parity1", perr1, perr_of(key));
    cyc = 0;
    while (busy1 === 1'b1 && cyc < 2000) begin
      if (timing && cyc < 3) chk("latency1", v1, cyc == 2);
      if (cyc == 2) fs = sk1;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 2000) chk("timeout1", 1'b0, 1'b1);
    if (timing) chk("busy_cycles1", cyc, 18);
    chk("drained1", q1.size(), 0);
    rr1 = 1'b0;
  endtask

  task automatic run3(input logic [191:0] keys, input logic [2:0] dec, input logic rr,
                      input logic timing);
    int cyc, bub;
    rr3 = rr;
    @(posedge clk); #1;
    key3 = keys; dec3 = dec; st3 = 1'b1;
    push(3, keys, dec, 3);
    @(posedge clk); #1;
    st3 = 1'b0;
    @(negedge clk);
    chk("busy_accept3", busy3, 1'b1);
    chk("parity3", perr3, {perr_of(keys[191:128]), perr_of(keys[127:64]), perr_of(keys[63:0])});
    cyc = 0;
    bub = 0;
    while (busy3 === 1'b1 && cyc < 4000) begin
      if (timing && cyc < 3) chk("latency3", v3, cyc == 2);
      if (cyc >= 2 && !v3) bub++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 4000) chk("timeout3", 1'b0, 1'b1);
    if (timing) begin
      chk("busy_cycles3", cyc, 52);
      chk("bubbles3", bub, 2);
    end
    chk("drained3", q3.size(), 0);
    rr3 = 1'b0;
  endtask

  task automatic wait_idle1();
    int cyc;
    cyc = 0;
    while (busy1 === 1'b1 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 2000) chk("timeout_idle1", 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] fs;
    int n;
    int base;
    reset = 1'b1;
    st1 = 1'b0; st3 = 1'b0; key1 = '0; key3 = '0; dec1 = '0; dec3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_valid1", v1, 1'b0);
    chk("rst_subkey1", sk1, 48'h0);
    chk("rst_idx1", {rnd1, kidx1, last1}, 7'h0);
    chk("rst_perr1", perr1, 1'b0);
    chk("rst_busy3", busy3, 1'b0);
    chk("rst_valid3", v3, 1'b0);
    chk("rst_perr3", perr3, 3'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    run1(KAT, 1'b0, 1'b0, 1'b1, fs);
    chk("kat_enc_first", fs, 48'h1B02EFFC7072);
    chk("kat_enc_last", last_sk1, 48'hCB3D8B0E17F5);
    run1(KAT, 1'b1, 1'b0, 1'b1, fs);
    chk("kat_dec_first", fs, 48'hCB3D8B0E17F5);
    chk("kat_dec_last", last_sk1, 48'h1B02EFFC7072);
    run1(KAT, 1'b0, 1'b1, 1'b0, fs);
    run1(64'h133457799BBCDFF0, 1'b0, 1'b0, 1'b1, fs);
    chk("par_first", fs, 48'h1B02EFFC7072);
    chk("par_last", last_sk1, 48'hCB3D8B0E17F5);

    run3({64'hFEDCBA9876543210, 64'h0E329232EA6D0D73, KAT}, 3'b010, 1'b0, 1'b1);

    // start raised during the final handshake must not begin a new load
    @(posedge clk); #1;
    key1 = KAT; dec1 = 1'b0; st1 = 1'b1;
    push(1, {128'h0, KAT}, 3'b000, 1);
    @(posedge clk); #1;
    st1 = 1'b0;
    repeat (18) @(negedge clk);
    chk("last_flag_end", last1, 1'b1);
    st1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0;
    @(negedge clk);
    chk("end_busy", busy1, 1'b0);
    chk("end_valid", v1, 1'b0);
    @(negedge clk);
    chk("late_start_ignored", busy1, 1'b0);
    chk("drained_end", q1.size(), 0);

    // reset right after the 7th handshake
    base = hs1;
    @(posedge clk); #1;
    key1 = 64'h0E329232EA6D0D73; dec1 = 1'b0; st1 = 1'b1;
    push(1, {128'h0, key1}, 3'b000, 1);
    @(posedge clk); #1;
    st1 = 1'b0;
    n = 0;
    while (hs1 - base < 7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("timeout_hs7", 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy1, 1'b0);
    chk("midrst_valid", v1, 1'b0);
    chk("midrst_subkey", sk1, 48'h0);
    chk("midrst_idx", {rnd1, kidx1, last1}, 7'h0);
    q1.delete();

    // restart from round 0; a second start while busy must be ignored
    @(posedge clk); #1;
    key1 = KAT; dec1 = 1'b0; st1 = 1'b1;
    push(1, {128'h0, KAT}, 3'b000, 1);
    @(posedge clk); #1;
    st1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    key1 = ~KAT; dec1 = 1'b1; st1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    st1 = 1'b0;
    @(negedge clk);
    wait_idle1();
    chk("busy_start_ignored", q1.size(), 0);
    repeat (3) @(negedge clk);
    chk("no_extra_load", busy1, 1'b0);

    for (int i = 0; i < 4; i++)
      run1({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b0, fs);
    for (int i = 0; i < 3; i++)
      run3({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           3'($urandom_range(0, 7)), 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
